// File: rtl/addmul_host_seq.sv
// addmul_host_seq: host-side sequencer for the adder/multiplier tile.
// Accepts {A, B, op} on a valid/ready request port, strobes the operands onto
// the tile pins, waits for the tile's result-ready flag (bounded by TIMEOUT),
// reads the 16-bit result back byte-wise and returns it on a valid/ready
// response port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1; the producer holds valid and its payload stable until that edge.
//
// Optional feature: define ADDMUL_HOST_CHECK_EN to build a golden model that
// flags rsp_mismatch when the tile result differs from A+B / A*B.
//
// Pin actions are registered one cycle behind the state that performs them,
// so a state's pin values appear on the edge that leaves it. dbg_state exposes
// the FSM state for checkers.
module addmul_host_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic        req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_error,
  output logic        rsp_mismatch,
  output logic [7:0]  pin_ui,
  output logic [7:0]  pin_uio,
  input  logic [7:0]  pin_uo,
  input  logic [7:0]  pin_uio_out,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_A  = 3'd1,
    ST_SEND_B  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_READ_LO = 3'd4,
    ST_READ_HI = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t     state, state_next;
  logic [7:0] a_q, b_q;
  logic       op_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_inc;
  logic       tile_ready;
  logic       unused_bits;

  assign tile_ready  = pin_uio_out[7];
  assign unused_bits = ^pin_uio_out[6:0];
  assign cnt_inc     = cnt_q + 8'd1;
  assign dbg_state   = state;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (req_valid && req_ready) state_next = ST_SEND_A;
      ST_SEND_A:  state_next = ST_SEND_B;
      ST_SEND_B:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (tile_ready)                  state_next = ST_READ_LO;
        else if (cnt_inc == TIMEOUT_C)   state_next = ST_RESP;
      end
      ST_READ_LO: state_next = ST_READ_HI;
      ST_READ_HI: state_next = ST_RESP;
      ST_RESP:    if (rsp_valid && rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Registered datapath: operand latch, pin drive, timeout count, response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_error  <= 1'b0;
      pin_ui     <= 8'h00;
      pin_uio    <= 8'h00;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 1'b0;
      cnt_q      <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            a_q       <= req_a;
            b_q       <= req_b;
            op_q      <= req_op;
            req_ready <= 1'b0;
          end
        end
        ST_SEND_A: begin
          pin_ui  <= a_q;
          pin_uio <= {4'b0000, 1'b0, 1'b0, op_q, 1'b1};
        end
        ST_SEND_B: begin
          pin_ui  <= b_q;
          pin_uio <= {4'b0000, 1'b0, 1'b1, op_q, 1'b1};
          cnt_q   <= 8'h00;
        end
        ST_WAIT: begin
          pin_ui  <= 8'h00;
          pin_uio <= {4'b0000, 1'b0, 1'b0, op_q, 1'b0};
          if (!tile_ready) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              rsp_error  <= 1'b1;
              rsp_result <= 16'h0000;
            end
          end
        end
        ST_READ_LO: begin
          pin_uio <= {4'b0000, 1'b0, 1'b0, op_q, 1'b0};
        end
        ST_READ_HI: begin
          // uo_out still reflects the low-byte select from the previous cycle
          pin_uio          <= {4'b0000, 1'b1, 1'b0, op_q, 1'b0};
          rsp_result[7:0]  <= pin_uo;
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            if (!rsp_error) rsp_result[15:8] <= pin_uo;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            pin_uio   <= 8'h00;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDMUL_HOST_CHECK_EN
  logic [15:0] golden;
  logic        mismatch_q;

  assign golden       = op_q ? (16'(a_q) * 16'(b_q)) : (16'(a_q) + 16'(b_q));
  assign rsp_mismatch = mismatch_q;

  // Compare the captured result against the golden model as RESP is entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (state == ST_RESP) begin
      if (!rsp_valid && !rsp_error) mismatch_q <= (golden != {pin_uo, rsp_result[7:0]});
      else if (rsp_valid && rsp_ready) mismatch_q <= 1'b0;
    end
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_addmul_host_seq.sv
// tb_addmul_host_seq: directed, table-driven bench for addmul_host_seq with a
// behavioural tile model (operand strobe capture, programmable ready delay,
// optional result corruption).
module tb_addmul_host_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid, req_ready, req_op;
  logic [7:0]  req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_mismatch;
  logic [15:0] rsp_result;
  logic [7:0]  pin_ui, pin_uio, pin_uo, pin_uio_out;
  logic [2:0]  dbg_state;

  addmul_host_seq #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_mismatch(rsp_mismatch),
    .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo), .pin_uio_out(pin_uio_out),
    .dbg_state(dbg_state)
  );

  // ---------------- tile model ----------------
  logic        t_always = 1'b0;
  int          t_delay = 0;
  logic        t_corrupt = 1'b0;
  logic [7:0]  t_a = 8'h00, t_b = 8'h00;
  logic        t_op = 1'b0;
  logic        t_ready = 1'b0;
  int          rdy_cnt = 0;
  logic [15:0] t_res;

  always @(posedge clk) begin
    if (pin_uio[0] && !pin_uio[2]) begin
      t_a     <= pin_ui;
      t_ready <= 1'b0;
    end
    if (pin_uio[0] && pin_uio[2]) begin
      t_b     <= pin_ui;
      t_op    <= pin_uio[1];
      rdy_cnt <= t_delay;
    end else if (rdy_cnt != 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) t_ready <= 1'b1;
    end
  end

  assign t_res       = (t_op ? (16'(t_a) * 16'(t_b)) : (16'(t_a) + 16'(t_b))) ^ {15'b0, t_corrupt};
  assign pin_uo      = pin_uio[3] ? t_res[15:8] : t_res[7:0];
  assign pin_uio_out = {t_always | t_ready, 7'h2A};

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        op;
    logic        always_rdy;
    int          delay;
    logic        corrupt;
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_lat;
    int          rsp_wait;
    logic        rsp_pre;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    int   acc;
    int   n;
    logic exp_mm;
    logic [15:0] res_exp;
`ifdef ADDMUL_HOST_CHECK_EN
    exp_mm = v.corrupt & ~v.exp_err;
`else
    exp_mm = 1'b0;
`endif
    exp_q.push_back(v.exp_res);
    t_always  = v.always_rdy;
    t_delay   = v.delay;
    t_corrupt = v.corrupt;
    rsp_ready = v.rsp_pre;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin acc = cyc + 1; break; end
      @(negedge clk);
    end
    chk("accept_seen", (acc >= 0), 1);
    @(negedge clk);
    // Busy now: a fresh request with different operands must be ignored
    req_a  = 8'h12;
    req_b  = 8'h77;
    req_op = ~v.op;
    chk("req_ready_busy", req_ready, 0);
    @(negedge clk);
    chk("pin_ui_a", pin_ui, v.a);
    chk("pin_uio_a", pin_uio, {6'b0, v.op, 1'b1});
    @(negedge clk);
    chk("pin_ui_b", pin_ui, v.b);
    chk("pin_uio_b", pin_uio, {5'b0, 1'b1, v.op, 1'b1});
    @(negedge clk);
    chk("pin_ui_wait", pin_ui, 0);
    chk("pin_uio_wait", pin_uio, {6'b0, v.op, 1'b0});
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("rsp_valid_seen", rsp_valid, 1);
    res_exp = exp_q.pop_front();
    chk("latency", cyc - acc, v.exp_lat);
    chk("rsp_result", rsp_result, res_exp);
    chk("rsp_error", rsp_error, v.exp_err);
    chk("rsp_mismatch", rsp_mismatch, exp_mm);
    if (!v.rsp_pre) begin
      for (int k = 0; k < v.rsp_wait; k++) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, res_exp);
        chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_error", rsp_error, 0);
    chk("post_pin_uio", pin_uio, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_error"}, rsp_error, 0);
    chk({tag, "_rsp_mismatch"}, rsp_mismatch, 0);
    chk({tag, "_pin_ui"}, pin_ui, 0);
    chk({tag, "_pin_uio"}, pin_uio, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int rises;
    // a, b, op, always_rdy, delay, corrupt, exp_res, exp_err, exp_lat, rsp_wait, rsp_pre
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 2, 1'b0, 16'h0100, 1'b0,  9, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1, 1'b0, 16'hFE01, 1'b0,  8, 5, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 16'hFE00, 1'b0,  6, 0, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 19, 2, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b1, 0, 1'b0, 16'h0100, 1'b0,  6, 0, 1'b1};
    vecs[5] = '{8'h0C, 8'h0B, 1'b1, 1'b0, 3, 1'b0, 16'h0084, 1'b0, 10, 1, 1'b0};
    vecs[6] = '{8'h00, 8'h5A, 1'b1, 1'b1, 0, 1'b0, 16'h0000, 1'b0,  6, 0, 1'b0};
    vecs[7] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 2, 1'b0, 16'h26AC, 1'b0,  9, 3, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_op = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting on the tile: request dropped, no strobe, no response
    t_always = 1'b0; t_delay = 0; t_corrupt = 1'b0;
    req_a = 8'h33; req_b = 8'h44; req_op = 1'b1; req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin acc = cyc + 1; break; end
      @(negedge clk);
    end
    chk("rst_accept_seen", (acc >= 0), 1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_in_wait_state", dbg_state, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_state("midreset");
    rises = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid) rises++;
    end
    chk("midreset_no_rsp", rises, 0);
    chk("midreset_pin_uio_idle", pin_uio, 0);

    run_vec('{8'h07, 8'h09, 1'b0, 1'b0, 1, 1'b0, 16'h0010, 1'b0, 8, 1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addmul_host_seq.md
# addmul_host_seq

Host-side sequencer that drives the adder/multiplier tile across its 8-bit pin interface. It takes one operand pair plus an opcode over a valid/ready request port, then serialises the operands onto the tile's `ui_in`/`uio_in` pins. It waits for the tile's result-ready flag, reads the 16-bit result back byte-wise from `uo_out`, and returns it on a valid/ready response port. It sits on the driving side of the tile, as the transmitter/reader for the tile's pin receiver.

## Interface
- `TIMEOUT`, 16: maximum WAIT cycles before aborting with error; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer idle and able to accept.
- `req_a` in 8: operand A.
- `req_b` in 8: operand B.
- `req_op` in 1: 0 = add, 1 = multiply.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_result` out 16: result, {high byte, low byte}.
- `rsp_error` out 1: timeout occurred; `rsp_result` = 0.
- `rsp_mismatch` out 1: golden-model check failed (see Configuration).
- `pin_ui` out 8: drives tile `ui_in` (operand byte).
- `pin_uio` out 8: drives tile `uio_in`. Bit 0 = strobe, bit 1 = op, bit 2 = operand select (0 = A, 1 = B), bit 3 = read select (0 = low, 1 = high). Bits 7:4 = 0.
- `pin_uo` in 8: tile `uo_out`, result byte selected by read select.
- `pin_uio_out` in 8: tile `uio_out`; bit 7 = result ready, other bits ignored.

## Operation
- Every output is registered.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_error`=0, `rsp_mismatch`=0, `pin_ui`=0, `pin_uio`=0, state IDLE, timeout counter 0.
- FSM states: IDLE, SEND_A, SEND_B, WAIT, READ_LO, READ_HI, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch A, B and op; deassert `req_ready`; go to SEND_A.
- SEND_A: `pin_ui`=A, `pin_uio`={4'b0, 0, 0, op, 1}; go to SEND_B.
- SEND_B: `pin_ui`=B, `pin_uio`={4'b0, 0, 1, op, 1}; clear counter; go to WAIT.
- WAIT:
  - Strobe=0, `pin_ui`=0, op bit held.
  - If `pin_uio_out[7]`=1, go to READ_LO.
  - Otherwise increment the counter. When counter reaches `TIMEOUT`, set `rsp_error`=1 and `rsp_result`=0, then go to RESP.
- READ_LO: read select=0; go to READ_HI.
- READ_HI: read select=1; capture `pin_uo` into `rsp_result[7:0]`; go to RESP.
- Entry to RESP from READ_HI: capture `pin_uo` into `rsp_result[15:8]` and set `rsp_valid`=1 on the same edge.
- RESP:
  - `rsp_valid`=1; all response fields held stable.
  - On `rsp_ready`, clear `rsp_valid`/`rsp_error`/`rsp_mismatch`, set `pin_uio`=0, go to IDLE, and assert `req_ready` on the next cycle.
- `req_valid` while busy is ignored and must not disturb latched operands.
- Result width: add is zero-extended 9-bit, mul is full 16-bit; the sequencer does not reinterpret the bytes.

## Timing
- Handshake fires at edge 0. `pin_*` show operand A for cycle 1 and operand B for cycle 2; WAIT starts at cycle 3.
- Minimum latency with ready seen in the first WAIT cycle: `rsp_valid` rises 6 cycles after the accept edge.
- Timeout path: `rsp_valid` rises `TIMEOUT`+3 cycles after accept.
- Back-to-back: next accept is no earlier than 1 cycle after the response handshake.
- `rsp_ready` asserted in the same cycle `rsp_valid` rises completes the transfer at that edge.
- Reset mid-operation: the next edge with `rst_n`=0 forces all reset values, including `pin_uio`=0, so no strobe leaks. An in-flight request is dropped with no response.
- Ready flag already high on WAIT entry: take it immediately (1 WAIT cycle).

## Configuration
- `ADDMUL_HOST_CHECK_EN` defined:
  - An internal golden model computes A+B (zero-extended) or A*B from the latched operands.
  - On entry to RESP from READ_HI, `rsp_mismatch` = (golden ≠ captured result).
  - `rsp_mismatch` is forced 0 on timeout.
- Not defined: `rsp_mismatch` tied 0 and no golden logic is synthesised.

## Test plan
- Add: A=0xFF, B=0x01, op=0, tile model ready after 2 cycles returning 0x0100 -> pins show 0xFF/strobe then 0x01/sel=1. `rsp_result`=0x0100, `rsp_error`=0, `rsp_mismatch`=0.
- Multiply: A=0xFF, B=0xFF, op=1 -> `rsp_result`=0xFE01. With the macro defined and the model corrupted to 0xFE00 -> `rsp_mismatch`=1.
- Timeout: tile never raises bit 7, `TIMEOUT`=16 -> `rsp_valid` at accept+19, `rsp_error`=1, `rsp_result`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles -> `rsp_valid` and `rsp_result` stable, `req_ready`=0. Second `req_valid` with A=0x12 is ignored.
- Reset in WAIT: `rst_n`=0 for one edge -> all outputs at reset values next cycle, `pin_uio`=0, no response; the following request completes normally.
- Minimum latency: ready high before WAIT -> `rsp_valid` exactly 6 cycles after accept. Immediate `rsp_ready` -> `req_ready` high 1 cycle later.
